// File: rtl/ad9643_pkg.sv
// Shared constants, instruction field layout and FSM encoding for the AD9643
// SPI front end.
//   ADDR_W / DATA_W : register file address / data widths
//   INSTR_W         : SPI instruction phase length in bits
//   LEN_*           : W1:W0 transfer-length encodings
//   state_t / ST_*  : SPI slave FSM state encoding
package ad9643_pkg;

   localparam int unsigned ADDR_W  = 13;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned INSTR_W = 16;

   // Instruction field positions
   localparam int unsigned RW_BIT  = 15;
   localparam int unsigned LEN_MSB = 14;
   localparam int unsigned LEN_LSB = 13;

   localparam logic [1:0] LEN_1      = 2'b00;
   localparam logic [1:0] LEN_2      = 2'b01;
   localparam logic [1:0] LEN_3      = 2'b10;
   localparam logic [1:0] LEN_STREAM = 2'b11;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_INSTR   = 3'd1;
   localparam state_t ST_WR_DATA = 3'd2;
   localparam state_t ST_RD_DATA = 3'd3;
   localparam state_t ST_DONE    = 3'd4;

   // True when the byte completing now is the final one of a fixed-length
   // transfer; done_cnt is the number of bytes already finished before it.
   function automatic logic is_last_byte(input logic [1:0] len,
                                         input logic [1:0] done_cnt);
      logic last;
      case (len)
         LEN_1:      last = (done_cnt == 2'd0);
         LEN_2:      last = (done_cnt == 2'd1);
         LEN_3:      last = (done_cnt == 2'd2);
         LEN_STREAM: last = 1'b0;
         default:    last = 1'b0;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/ad9643_spi_slave_if.sv
// SPI pad and register-file bus bundle for the AD9643 SPI slave.
//   csb, sclk, sdio_i        : SPI pad inputs
//   sdio_o, sdio_oe          : SDIO pad output value and enable
//   reg_write/addr/wdata     : register file write port
//   reg_rdata                : combinational read data for reg_addr
//   busy                     : frame in progress
interface ad9643_spi_slave_if;
   import ad9643_pkg::*;

   logic              csb;
   logic              sclk;
   logic              sdio_i;
   logic              sdio_o;
   logic              sdio_oe;
   logic              reg_write;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic [DATA_W-1:0] reg_rdata;
   logic              busy;

   modport slave (
      input  csb, sclk, sdio_i, reg_rdata,
      output sdio_o, sdio_oe, reg_write, reg_addr, reg_wdata, busy
   );

   modport master (
      output csb, sclk, sdio_i, reg_rdata,
      input  sdio_o, sdio_oe, reg_write, reg_addr, reg_wdata, busy
   );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer followed by rise/fall pulse generation in clk domain.
//   clk, reset : system clock, async active-high reset
//   d          : asynchronous input
//   rise_c     : one-clk pulse on a synchronized 0->1 transition
//   fall_c     : one-clk pulse on a synchronized 1->0 transition
module spi_edge_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   // Shift chain plus one delayed copy for edge detection
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise_c =  sync_q[STAGES-1] & ~prev_q;
   assign fall_c = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/ad9643_spi_slave.sv
// AD9643 3-wire SPI slave front end: decodes instruction + data frames in the
// clk domain, drives register-file writes and shifts read data out on SDIO.
//   clk, reset : system clock (>= 8x SCLK), async active-high reset
//   bus        : SPI pads and register-file port (ad9643_spi_slave_if.slave)
module ad9643_spi_slave
   import ad9643_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   ad9643_spi_slave_if.slave  bus
);

   logic csb_rise, csb_fall;
   logic sclk_rise, sclk_fall;
   logic sdio_s;

   // csb resets low so a csb already low at reset release cannot start a
   // frame; only a genuine high->low transition does.
   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csb_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (bus.csb),
      .rise_c (csb_rise),
      .fall_c (csb_fall)
   );

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (bus.sclk),
      .rise_c (sclk_rise),
      .fall_c (sclk_fall)
   );

   // SDIO needs the same latency as SCLK so data lines up with the edge pulse
   logic [SYNC_STAGES-1:0] sdio_sync_q, sdio_sync_d;

   always_comb begin
      sdio_sync_d = {sdio_sync_q[SYNC_STAGES-2:0], bus.sdio_i};
   end

   assign sdio_s = sdio_sync_q[SYNC_STAGES-1];

   state_t               state_q,    state_d;
   logic [3:0]           bit_cnt_q,  bit_cnt_d;
   logic [INSTR_W-2:0]   shift_q,    shift_d;
   logic [1:0]           len_q,      len_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic                 dec_q,      dec_d;
   logic [ADDR_W-1:0]    addr_q,     addr_d;
   logic [DATA_W-1:0]    wdata_q,    wdata_d;
   logic [DATA_W-1:0]    rd_shift_q, rd_shift_d;
   logic                 write_q,    write_d;
   logic                 sdio_o_q,   sdio_o_d;
   logic                 sdio_oe_q,  sdio_oe_d;
   logic                 busy_q,     busy_d;
   logic [INSTR_W-1:0]   shift_in;
   logic                 last_byte;

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      dec_d      = 1'b0;
      // Pending decrement lands one clk after the strobe / byte end
      addr_d     = dec_q ? (addr_q - ADDR_W'(1)) : addr_q;
      wdata_d    = wdata_q;
      rd_shift_d = rd_shift_q;
      write_d    = 1'b0;
      sdio_o_d   = sdio_o_q;
      shift_in   = {shift_q, sdio_s};
      last_byte  = is_last_byte(len_q, byte_cnt_q);

      case (state_q)
         ST_IDLE: begin
            if (csb_fall) begin
               state_d   = ST_INSTR;
               bit_cnt_d = 4'd0;
            end
         end

         ST_INSTR: begin
            if (sclk_rise) begin
               shift_d   = shift_in[INSTR_W-2:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(INSTR_W - 1)) begin
                  state_d    = shift_in[RW_BIT] ? ST_RD_DATA : ST_WR_DATA;
                  addr_d     = shift_in[ADDR_W-1:0];
                  len_d      = shift_in[LEN_MSB:LEN_LSB];
                  byte_cnt_d = 2'd0;
                  bit_cnt_d  = 4'd0;
               end
            end
         end

         ST_WR_DATA: begin
            if (sclk_rise) begin
               shift_d   = shift_in[INSTR_W-2:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(DATA_W - 1)) begin
                  bit_cnt_d  = 4'd0;
                  wdata_d    = shift_in[DATA_W-1:0];
                  write_d    = 1'b1;
                  dec_d      = 1'b1;
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  if (last_byte) state_d = ST_DONE;
               end
            end
         end

         ST_RD_DATA: begin
            // bit_cnt == 0 on a fall means a fresh byte: reload from reg_rdata
            if (sclk_fall) begin
               if (bit_cnt_q == 4'd0) begin
                  sdio_o_d   = bus.reg_rdata[DATA_W-1];
                  rd_shift_d = {bus.reg_rdata[DATA_W-2:0], 1'b0};
               end else begin
                  sdio_o_d   = rd_shift_q[DATA_W-1];
                  rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
               end
            end
            if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(DATA_W - 1)) begin
                  bit_cnt_d  = 4'd0;
                  dec_d      = 1'b1;
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  if (last_byte) state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_DONE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // SCLK work above is done first, so a coincident csb rise still lets
      // the completing byte's write through.
      if (csb_rise) state_d = ST_IDLE;

      sdio_oe_d = (state_d == ST_RD_DATA) &&
                  (sdio_oe_q || ((state_q == ST_RD_DATA) && sclk_fall));
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sdio_sync_q <= '0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= '0;
         len_q       <= 2'd0;
         byte_cnt_q  <= 2'd0;
         dec_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_shift_q  <= '0;
         write_q     <= 1'b0;
         sdio_o_q    <= 1'b0;
         sdio_oe_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sdio_sync_q <= sdio_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         dec_q       <= dec_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_shift_q  <= rd_shift_d;
         write_q     <= write_d;
         sdio_o_q    <= sdio_o_d;
         sdio_oe_q   <= sdio_oe_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.sdio_o    = sdio_o_q;
   assign bus.sdio_oe   = sdio_oe_q;
   assign bus.reg_write = write_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ad9643_spi_slave.sv
// Self-checking bench for ad9643_spi_slave: directed frames plus randomized
// frames, checked against a frame-level reference model of the register file.
module tb_ad9643_spi_slave;
   import ad9643_pkg::*;

   localparam int unsigned MEM_DEPTH = 8192;
   localparam int unsigned HALF_SCLK = 50;

   logic clk;
   logic reset;
   logic mem_init;

   ad9643_spi_slave_if bus_if ();

   ad9643_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file seen by the DUT
   logic [7:0] regfile [0:MEM_DEPTH-1];
   logic [7:0] ref_mem [0:MEM_DEPTH-1];

   function automatic logic [7:0] init_val(input logic [12:0] a);
      if (a == 13'd1) return 8'h82;
      return a[7:0] ^ {a[12:8], 3'b101};
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_DEPTH; i++) regfile[i] <= init_val(13'(i));
      end else if (bus_if.reg_write) begin
         regfile[bus_if.reg_addr] <= bus_if.reg_wdata;
      end
   end

   assign bus_if.reg_rdata = regfile[bus_if.reg_addr];

   // Write strobe and output-enable monitor
   logic [20:0] wr_q [$];
   int          oe_cnt;

   initial oe_cnt = 0;

   always @(negedge clk) begin
      if (bus_if.reg_write) wr_q.push_back({bus_if.reg_addr, bus_if.reg_wdata});
      if (bus_if.sdio_oe) oe_cnt <= oe_cnt + 1;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] tx_bytes  [0:7];
   logic [7:0] rx_bytes  [0:7];
   bit         rx_oe_all [0:7];
   bit         rx_oe_any [0:7];
   int         wr_base;
   int         oe_base;
   logic       busy_mid;

   task automatic spi_bit(input logic b, input bit end_cs, output logic so, output logic oe);
      bus_if.sdio_i = b;
      #(HALF_SCLK);
      so = bus_if.sdio_o;
      oe = bus_if.sdio_oe;
      bus_if.sclk = 1'b1;
      if (end_cs) bus_if.csb = 1'b1;
      #(HALF_SCLK);
      bus_if.sclk = 1'b0;
   endtask

   task automatic spi_frame(input logic [15:0] instr, input int nbytes, input int extra,
                            input bit coincide);
      logic so, oe;
      logic [7:0] b;
      bit end_cs;
      bit cs_up;
      cs_up = 1'b0;
      @(negedge clk);
      wr_base = wr_q.size();
      oe_base = oe_cnt;
      bus_if.csb = 1'b0;
      #(2 * HALF_SCLK);
      for (int i = 15; i >= 0; i--) begin
         spi_bit(instr[i], 1'b0, so, oe);
         if (i == 0) busy_mid = bus_if.busy;
      end
      for (int k = 0; k < nbytes; k++) begin
         b = tx_bytes[k];
         rx_oe_all[k] = 1'b1;
         rx_oe_any[k] = 1'b0;
         for (int i = 7; i >= 0; i--) begin
            end_cs = coincide && (k == nbytes - 1) && (i == 0) && (extra == 0);
            spi_bit(b[i], end_cs, so, oe);
            if (end_cs) cs_up = 1'b1;
            rx_bytes[k][i] = so;
            rx_oe_all[k] = rx_oe_all[k] & oe;
            rx_oe_any[k] = rx_oe_any[k] | oe;
         end
      end
      for (int i = 0; i < extra; i++) spi_bit(1'($urandom_range(0, 1)), 1'b0, so, oe);
      if (!cs_up) begin
         #(2 * HALF_SCLK);
         bus_if.csb = 1'b1;
      end
      #(6 * HALF_SCLK);
   endtask

   // Reference model: what a frame should have done to the register file
   task automatic check_frame(input logic [15:0] instr, input int nbytes);
      logic        rw;
      logic [1:0]  w;
      logic [12:0] a;
      logic [20:0] e;
      int          nexp;
      rw = instr[15];
      w  = instr[14:13];
      a  = instr[12:0];
      if (w == 2'b11) nexp = nbytes;
      else            nexp = (int'(w) + 1 < nbytes) ? int'(w) + 1 : nbytes;
      check("busy_mid", 32'(busy_mid), 32'd1);
      if (!rw) begin
         check("wr_count", 32'(wr_q.size() - wr_base), 32'(nexp));
         for (int k = 0; k < nexp; k++) begin
            if (wr_base + k < wr_q.size()) begin
               e = wr_q[wr_base + k];
               check("wr_addr", 32'(e[20:8]), 32'(a));
               check("wr_data", 32'(e[7:0]), 32'(tx_bytes[k]));
            end
            ref_mem[a] = tx_bytes[k];
            a = a - 13'd1;
         end
         check("wr_oe_seen", 32'(oe_cnt - oe_base), 32'd0);
      end else begin
         check("rd_no_write", 32'(wr_q.size() - wr_base), 32'd0);
         for (int k = 0; k < nbytes; k++) begin
            if (k < nexp) begin
               check("rd_byte", 32'(rx_bytes[k]), 32'(ref_mem[a]));
               check("rd_oe_on", 32'(rx_oe_all[k]), 32'd1);
               a = a - 13'd1;
            end else begin
               check("rd_oe_off", 32'(rx_oe_any[k]), 32'd0);
            end
         end
      end
      check("busy_end", 32'(bus_if.busy), 32'd0);
      check("oe_end", 32'(bus_if.sdio_oe), 32'd0);
   endtask

   task automatic run(input logic [15:0] instr, input int nbytes, input int extra,
                      input bit coincide);
      spi_frame(instr, nbytes, extra, coincide);
      check_frame(instr, nbytes);
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_sdio_oe"},   32'(bus_if.sdio_oe),   32'd0);
      check({pfx, "_sdio_o"},    32'(bus_if.sdio_o),    32'd0);
      check({pfx, "_reg_write"}, 32'(bus_if.reg_write), 32'd0);
      check({pfx, "_reg_addr"},  32'(bus_if.reg_addr),  32'd0);
      check({pfx, "_reg_wdata"}, 32'(bus_if.reg_wdata), 32'd0);
      check({pfx, "_busy"},      32'(bus_if.busy),      32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic so, oe;
      logic [15:0] instr;
      int nb, ex;
      reset         = 1'b1;
      mem_init      = 1'b1;
      bus_if.csb    = 1'b1;
      bus_if.sclk   = 1'b0;
      bus_if.sdio_i = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_val(13'(i));
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      check_outputs_zero("rst0");
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Single-byte write
      tx_bytes[0] = 8'h03;
      run(16'h000B, 1, 0, 1'b0);

      // Three-byte write with extra bytes clocked after the count is reached
      tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB; tx_bytes[2] = 8'hCC;
      tx_bytes[3] = 8'h5A; tx_bytes[4] = 8'hA5;
      run(16'h4010, 5, 0, 1'b0);

      // Single-byte read of address 1, second byte must not be driven
      run(16'h8001, 2, 0, 1'b0);
      check("t3_byte", 32'(rx_bytes[0]), 32'h82);

      // Streaming write wrapping below address 0
      tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
      run(16'h6000, 2, 0, 1'b0);

      // Aborted partial byte, then a clean frame
      run(16'h0020, 0, 5, 1'b0);
      tx_bytes[0] = 8'h5A;
      run(16'h0021, 1, 0, 1'b0);

      // csb rises together with the final SCLK rise of a byte
      tx_bytes[0] = 8'h77; tx_bytes[1] = 8'h88;
      run(16'h2100, 2, 0, 1'b1);

      // Reset asserted in the middle of a read byte
      @(negedge clk);
      bus_if.csb = 1'b0;
      #(2 * HALF_SCLK);
      instr = 16'h8005;
      for (int i = 15; i >= 0; i--) spi_bit(instr[i], 1'b0, so, oe);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, so, oe);
      check("rst_pre_oe", 32'(bus_if.sdio_oe), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      check_outputs_zero("rst_mid");
      bus_if.csb = 1'b1;
      #(HALF_SCLK);
      @(negedge clk);
      reset = 1'b0;
      #(2 * HALF_SCLK);
      tx_bytes[0] = 8'h3C;
      run(16'h0100, 1, 0, 1'b0);
      run(16'h8100, 1, 0, 1'b0);

      // Randomized frames
      for (int n = 0; n < 24; n++) begin
         instr[15]    = 1'($urandom_range(0, 1));
         instr[14:13] = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) instr[12:0] = 13'($urandom_range(0, 2));
         else                           instr[12:0] = 13'($urandom_range(0, MEM_DEPTH - 1));
         nb = $urandom_range(0, 5);
         ex = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom);
         run(instr, nb, ex, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
